// File: rtl/ahb_slv_mem_responder.sv
// rtl/ahb_slv_mem_responder.sv - AHB slave responder: backing memory, wait states, error window, grant model
// Optional macro AHB_RSP_ECC_EN: read data returned as a SECDED(26,6) codeword (DATA_W must be 32).
module ahb_slv_mem_responder #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MEM_DEPTH   = 256,
  parameter int unsigned       WAIT_MODE   = 0,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [15:0]       LFSR_SEED   = 16'hACE1,
  parameter logic [ADDR_W-1:0] ERR_BASE    = 32'hFFFF_F000,
  parameter logic [ADDR_W-1:0] ERR_LIMIT   = 32'hFFFF_FFFF,
  parameter logic [3:0]        MASTER_ID   = 4'd1,
  parameter int                OUT_DLY     = 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hbusreq,
  input  logic              hlock,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic              hgrant,
  output logic [3:0]        hmaster
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

`ifdef AHB_RSP_ECC_EN
  localparam bit ECC_BAD = (DATA_W != 32);
`else
  localparam bit ECC_BAD = 1'b0;
`endif

  if (!(DATA_W == 32 || DATA_W == 64) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) ||
      WAIT_CYCLES > 15 || LFSR_SEED == 16'h0000 || OUT_DLY < 0 || ECC_BAD) begin : g_param_err
    $error("ahb_slv_mem_responder: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_DATA, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [3:0]        wait_cnt;
  logic [15:0]       lfsr;
  logic              dp_valid;
  logic              dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [LSB-1:0]    dp_lo;
  logic [2:0]        dp_size;
  logic              accept;
  logic              in_err;
  logic              commit;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              unused_ok;

  assign unused_ok = &{1'b0, hburst};

  assign hready = (state == ST_DATA) || (state == ST_ERR2);
  assign hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
  assign accept = hsel && hready && htrans[1];
  // Widened by one bit so an all-ones limit does not make the compare constant.
  assign in_err = ({1'b0, haddr} >= {1'b0, ERR_BASE}) && ({1'b0, haddr} <= {1'b0, ERR_LIMIT});

  if (WAIT_MODE == 1) begin : g_rand_wait
    assign wait_cnt = 4'({1'b0, lfsr[3:0]} % 5'(WAIT_CYCLES + 1));
  end else begin : g_fixed_wait
    assign wait_cnt = 4'(WAIT_CYCLES);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt == 4'd0) state_next = ST_DATA;
        else             cnt_next   = cnt - 4'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        state_next = ST_DATA;
        if (accept) begin
          if (in_err) begin
            state_next = ST_ERR1;
          end else if (wait_cnt != 4'd0) begin
            state_next = ST_WAIT;
            cnt_next   = wait_cnt - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_DATA;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      lfsr     <= LFSR_SEED;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lo    <= '0;
      dp_size  <= 3'd0;
    end else if (hready) begin
      // Error-window transfers never open a memory data phase.
      dp_valid <= accept && !in_err;
      if (accept) begin
        dp_write <= hwrite;
        dp_idx   <= haddr[IDX_W+LSB-1:LSB];
        dp_lo    <= haddr[LSB-1:0];
        dp_size  <= hsize;
        lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
    end
  end

  // A lane is written when it shares the size-aligned block of the captured address.
  always_comb begin
    be = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (((b ^ int'(dp_lo)) >> dp_size) == 0) be[b] = 1'b1;
    end
  end

  assign commit = (state == ST_DATA) && dp_valid && dp_write;
  assign rword  = mem[dp_idx];

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[dp_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

`ifdef AHB_RSP_ECC_EN
  function automatic logic [31:0] secded_enc(input logic [25:0] d);
    logic [31:0] c;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      for (int p = 1; p < 32; p++) begin
        if (p != (1 << j) && ((p >> j) & 1) == 1) c[(1<<j)-1] = c[(1<<j)-1] ^ c[p-1];
      end
    end
    c[31] = ^c[30:0];
    return c;
  endfunction

  logic unused_ecc;
  assign unused_ecc = &{1'b0, hwdata[DATA_W-1:26], rword[DATA_W-1:26]};
  assign wdata      = DATA_W'(hwdata[25:0]);

  always_comb begin
    hrdata = '0;
    if (dp_valid && !dp_write) hrdata = DATA_W'(secded_enc(rword[25:0]));
  end
`else
  assign wdata = hwdata;

  always_comb begin
    hrdata = '0;
    if (dp_valid && !dp_write) hrdata = rword;
  end
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant  <= 1'b0;
      hmaster <= 4'd0;
    end else begin
      if (hbusreq)               hgrant <= 1'b1;
      else if (!hlock && hready) hgrant <= 1'b0;
      if (hready) hmaster <= hgrant ? MASTER_ID : 4'd0;
    end
  end

endmodule

// File: tb/tb_ahb_slv_mem_responder.sv
// tb/tb_ahb_slv_mem_responder.sv - randomized self-checking bench for ahb_slv_mem_responder
module tb_ahb_slv_mem_responder;

  localparam int          WAITS = 3;
  localparam int          DEPTH = 256;
  localparam logic [3:0]  MID   = 4'd1;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [31:0] EBASE = 32'hFFFF_F000;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hbusreq = 1'b0;
  logic        hlock = 1'b0;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic        hgrant;
  logic [3:0]  hmaster;

  always #5 hclk = ~hclk;

  ahb_slv_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .WAIT_MODE(1), .WAIT_CYCLES(WAITS),
    .LFSR_SEED(SEED), .ERR_BASE(EBASE), .ERR_LIMIT(32'hFFFF_FFFF), .MASTER_ID(MID), .OUT_DLY(1)
  ) u_dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hbusreq(hbusreq),
    .hlock(hlock), .hrdata(hrdata), .hready(hready), .hresp(hresp), .hgrant(hgrant),
    .hmaster(hmaster)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       seq_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

`ifdef AHB_RSP_ECC_EN
  // Parity bits equal the XOR of the positions holding a 1 data bit.
  function automatic logic [31:0] ecc_enc(input logic [25:0] d);
    logic [31:0] c;
    int          syn;
    int          k;
    c = '0; syn = 0; k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        if (d[k]) syn = syn ^ p;
        k++;
      end
    end
    for (int j = 0; j < 5; j++) c[(1<<j)-1] = syn[j];
    c[31] = ^c[30:0];
    return c;
  endfunction
`endif

  function automatic logic [31:0] model_read(input logic [31:0] a);
`ifdef AHB_RSP_ECC_EN
    return ecc_enc(m_mem[idx_of(a)][25:0]);
`else
    return m_mem[idx_of(a)];
`endif
  endfunction

  task automatic model_write(input xfer_t x);
    for (int k = 0; k < (1 << x.size); k++) begin
      logic [31:0] ba;
      int          lane;
      ba   = (x.addr & ~((32'd1 << x.size) - 32'd1)) + 32'(k);
      lane = int'(ba[1:0]);
      m_mem[idx_of(x.addr)][8*lane +: 8] = x.data[8*lane +: 8];
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] data);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size; x.addr = addr; x.data = data;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.sel   = ($urandom_range(0, 99) < 92);
    x.trans = ($urandom_range(0, 9) < 8) ? ($urandom_range(0, 1) ? 2'b10 : 2'b11)
                                         : ($urandom_range(0, 1) ? 2'b00 : 2'b01);
    x.wr    = 1'($urandom_range(0, 1));
    x.size  = 3'($urandom_range(0, 2));
    x.addr  = ($urandom_range(0, 7) == 0) ? (EBASE | ($urandom & 32'h0000_0FFF)) : $urandom;
    x.addr  = x.addr & ~((32'd1 << x.size) - 32'd1);
    x.data  = $urandom;
    return x;
  endfunction

  task automatic check_rst(input string pfx);
    check_eq({pfx, "_hready"}, 32'(hready), 32'd1);
    check_eq({pfx, "_hresp"}, 32'(hresp), 32'd0);
    check_eq({pfx, "_hrdata"}, hrdata, 32'd0);
    check_eq({pfx, "_hgrant"}, 32'(hgrant), 32'd0);
    check_eq({pfx, "_hmaster"}, 32'(hmaster), 32'd0);
  endtask

  // Entered just after a rising edge that opened the data phase of p; leaves just after the completing edge.
  task automatic check_dphase(input xfer_t p);
    int w;
    int cnt;
    if (!(p.sel && p.trans[1])) begin
      @(negedge hclk);
      check_eq("idle_hready", 32'(hready), 32'd1);
      check_eq("idle_hresp", 32'(hresp), 32'd0);
      check_eq("idle_hrdata", hrdata, 32'd0);
    end else if (p.addr >= EBASE) begin
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge hclk);
      check_eq("err1_hready", 32'(hready), 32'd0);
      check_eq("err1_hresp", 32'(hresp), 32'd1);
      check_eq("err_hrdata", hrdata, 32'd0);
      @(negedge hclk);
      check_eq("err2_hready", 32'(hready), 32'd1);
      check_eq("err2_hresp", 32'(hresp), 32'd1);
    end else begin
      w      = int'(m_lfsr[3:0]) % (WAITS + 1);
      m_lfsr = lfsr_next(m_lfsr);
      cnt    = 0;
      @(negedge hclk);
      while (hready !== 1'b1 && cnt < 40) begin
        check_eq("wait_hresp", 32'(hresp), 32'd0);
        cnt++;
        @(negedge hclk);
      end
      check_eq("wait_count", 32'(cnt), 32'(w));
      check_eq("done_hresp", 32'(hresp), 32'd0);
      if (!p.wr) check_eq("rdata", hrdata, model_read(p.addr));
      else       model_write(p);
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic run_seq();
    xfer_t idle;
    xfer_t prev;
    xfer_t cur;
    idle = mk(1'b0, 3'd2, 32'd0, 32'd0);
    idle.sel = 1'b0;
    idle.trans = 2'b00;
    prev = idle;
    for (int i = 0; i <= seq_q.size(); i++) begin
      cur    = (i < seq_q.size()) ? seq_q[i] : idle;
      hsel   = cur.sel;
      haddr  = cur.addr;
      htrans = cur.trans;
      hwrite = cur.wr;
      hsize  = cur.size;
      hburst = 3'($urandom_range(0, 7));
      hwdata = prev.data;
      check_dphase(prev);
      prev = cur;
    end
    seq_q.delete();
  endtask

  task automatic grant_test();
    hbusreq = 1'b1;
    @(negedge hclk); check_eq("gnt_before", 32'(hgrant), 32'd0);
    @(negedge hclk); check_eq("gnt_set", 32'(hgrant), 32'd1);
    check_eq("master_lag", 32'(hmaster), 32'd0);
    @(negedge hclk); check_eq("master_set", 32'(hmaster), 32'(MID));
    hbusreq = 1'b0;
    hlock   = 1'b1;
    repeat (3) @(negedge hclk);
    check_eq("gnt_locked", 32'(hgrant), 32'd1);
    hlock = 1'b0;
    @(negedge hclk); check_eq("gnt_clr", 32'(hgrant), 32'd0);
    check_eq("master_hold", 32'(hmaster), 32'(MID));
    @(negedge hclk); check_eq("master_clr", 32'(hmaster), 32'd0);
    @(posedge hclk);
    #1;
  endtask

  task automatic reset_mid_wait();
    logic [31:0] a;
    int          tries;
    a     = 32'h0000_0080;
    tries = 0;
    while ((int'(m_lfsr[3:0]) % (WAITS + 1)) == 0 && tries < 20) begin
      seq_q.push_back(mk(1'b0, 3'd2, a, 32'd0));
      run_seq();
      tries++;
    end
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    hbusreq = 1'b1;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~m_mem[idx_of(a)];
    @(negedge hclk);
    check_eq("mid_wait_hready", 32'(hready), 32'd0);
    hresetn = 1'b0;
    #1;
    check_rst("rst_mid");
    hbusreq = 1'b0;
    m_lfsr  = SEED;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    seq_q.push_back(mk(1'b0, 3'd2, a, 32'd0));
    run_seq();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_lfsr = SEED;
    #3;
    check_rst("rst");
    repeat (3) @(posedge hclk);
    #1;
    hresetn = 1'b1;

    seq_q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h10, 32'd0));
    run_seq();

    seq_q.push_back(mk(1'b0, 3'd2, 32'hFFFF_F004, 32'd0));
    seq_q.push_back(mk(1'b1, 3'd2, 32'h20, 32'h5A5A_1234));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h20, 32'd0));
    seq_q.push_back(mk(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h0BAD_0BAD));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h0000_0FFC, 32'd0));
    run_seq();

    seq_q.push_back(mk(1'b1, 3'd2, 32'h10, 32'h1122_3344));
    seq_q.push_back(mk(1'b1, 3'd0, 32'h13, 32'hAB00_0000));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h10, 32'd0));
    seq_q.push_back(mk(1'b1, 3'd1, 32'h12, 32'h7788_0000));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h10, 32'd0));
    seq_q.push_back(mk(1'b1, 3'd2, 32'h40, 32'h0000_0001));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h40, 32'd0));
    seq_q.push_back(mk(1'b0, 3'd2, 32'h440, 32'd0));
    run_seq();

    grant_test();

    for (int i = 0; i < DEPTH; i++) seq_q.push_back(mk(1'b1, 3'd2, 32'(i * 4), $urandom));
    run_seq();

    reset_mid_wait();

    for (int i = 0; i < 400; i++) seq_q.push_back(rand_xfer());
    run_seq();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
